aes_inv_mixcolumns_wddl_seq: RTL and testbench

- Iterative WDDL dual-rail AES InvMixColumns for the decryption datapath; the inverse counterpart of the forward dual-rail MixColumns.
- Takes a full 128-bit state as true/complement rails and processes one 32-bit column per evaluate phase.
- Alternates precharge (spacer, all rails 0) and evaluate phases so each column evaluation is preceded by a spacer.
- Presents the result on dual-rail outputs with valid/ready handshakes on both sides.

---
 rtl/aes_inv_mixcolumns_wddl_seq.sv | 107 ++++++++++
 tb/tb_aes_inv_mixcolumns_wddl_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/aes_inv_mixcolumns_wddl_seq.sv
// aes_inv_mixcolumns_wddl_seq: iterative dual-rail (WDDL) AES InvMixColumns, one column per evaluate phase
module aes_inv_mixcolumns_wddl_seq #(
  parameter bit PRECHARGE_EN = 1'b1,
  parameter bit CHECK_RAILS = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_p,
  input  logic [127:0] state_n,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] result_p,
  output logic [127:0] result_n,
  output logic         rail_err
);
  localparam logic [1:0] IDLE = 2'd0, PRE = 2'd1, EVAL = 2'd2, DONE = 2'd3;
  // Dual-rail bytes are packed {true[7:0], complement[7:0]}; all-zero is the spacer.
  function automatic logic [1:0] x1(input logic [1:0] a, input logic [1:0] b);
    return {(a[1] & b[0]) | (a[0] & b[1]), (a[1] & b[1]) | (a[0] & b[0])};
  endfunction
  function automatic logic [15:0] xb(input logic [15:0] a, input logic [15:0] b);
    return {(a[15:8] & b[7:0]) | (a[7:0] & b[15:8]), (a[15:8] & b[15:8]) | (a[7:0] & b[7:0])};
  endfunction
  // xtime: only bits 1,3,4 need an XOR with the msb; bit 0 is the msb itself, so no constant rails appear.
  function automatic logic [15:0] xt(input logic [15:0] a);
    logic [7:0] p, n;
    logic [1:0] h, b1, b3, b4;
    p = a[15:8];
    n = a[7:0];
    h = {p[7], n[7]};
    b1 = x1({p[0], n[0]}, h);
    b3 = x1({p[2], n[2]}, h);
    b4 = x1({p[3], n[3]}, h);
    return {p[6], p[5], p[4], b4[1], b3[1], p[1], b1[1], p[7],
            n[6], n[5], n[4], b4[0], b3[0], n[1], b1[0], n[7]};
  endfunction
  // Returns {0e*a, 0b*a, 0d*a, 09*a} on both rails.
  function automatic logic [63:0] mulv(input logic [15:0] a);
    logic [15:0] x2, x4, x8, m9;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    m9 = xb(x8, a);
    return {xb(xb(x8, x4), x2), xb(m9, x2), xb(m9, x4), m9};
  endfunction
  logic [1:0] state_q, col_q;
  logic [3:0][31:0] cap_q, res_p_q, res_n_q;
  logic ov_q, err_q;
  logic [31:0] cw, bo_p, bo_n;
  logic [15:0] din [4];
  logic [63:0] m [4];
  logic [15:0] bo [4];
  assign cw = cap_q[~col_q];
  // The column datapath sees the true rail and its regenerated complement only in EVAL; otherwise the spacer.
  for (genvar g = 0; g < 4; g++) begin : g_row
    assign din[g] = (state_q == EVAL) ? {cw[31-8*g -: 8], ~cw[31-8*g -: 8]} : 16'h0;
    assign m[g] = mulv(din[g]);
    assign bo[g] = xb(xb(m[g][63:48], m[(g+1)%4][47:32]), xb(m[(g+2)%4][31:16], m[(g+3)%4][15:0]));
    assign bo_p[31-8*g -: 8] = bo[g][15:8];
    assign bo_n[31-8*g -: 8] = bo[g][7:0];
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = ov_q;
  assign result_p = ov_q ? res_p_q : '0;
  assign result_n = ov_q ? res_n_q : '0;
  assign rail_err = ov_q & err_q;
  // Sequencer: capture, alternate spacer/evaluate per column, then hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q <= '0;
      cap_q <= '0;
      res_p_q <= '0;
      res_n_q <= '0;
      ov_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          cap_q <= state_p;
          res_p_q <= '0;
          res_n_q <= '0;
          err_q <= CHECK_RAILS ? |(~(state_p ^ state_n)) : 1'b0;
          col_q <= '0;
          state_q <= PRECHARGE_EN ? PRE : EVAL;
        end
        PRE: state_q <= EVAL;
        EVAL: begin
          res_p_q[~col_q] <= bo_p;
          res_n_q[~col_q] <= bo_n;
          if (col_q == 2'd3) state_q <= DONE;
          else begin
            col_q <= col_q + 2'd1;
            state_q <= PRECHARGE_EN ? PRE : EVAL;
          end
        end
        default: if (!ov_q) ov_q <= 1'b1;
        else if (out_ready) begin
          ov_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_mixcolumns_wddl_seq.sv
// tb_aes_inv_mixcolumns_wddl_seq: directed checks of the dual-rail InvMixColumns sequencer
module tb_aes_inv_mixcolumns_wddl_seq;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, sel = 1'b0;
  logic [127:0] sp = '0, sn = '0;
  logic ir1, ov1, re1, ir0, ov0, re0;
  logic [127:0] rp1, rn1, rp0, rn0;
  int nvec = 0, nerr = 0, lat;
  logic spc_bad;
  wire ir = sel ? ir0 : ir1;
  wire ov = sel ? ov0 : ov1;
  wire re = sel ? re0 : re1;
  wire [127:0] rp = sel ? rp0 : rp1;
  wire [127:0] rn = sel ? rn0 : rn1;
  localparam logic [127:0] SINGLE = 128'h8e4da1bc_01010101_01010101_01010101;
  localparam logic [127:0] SINGLE_X = 128'hdb135345_01010101_01010101_01010101;
  localparam logic [127:0] FULL = 128'h9fdc589d_8e4da1bc_c6c6c6c6_01010101;
  localparam logic [127:0] FULL_X = 128'hf20a225c_db135345_c6c6c6c6_01010101;
  always #5 clk = ~clk;
  aes_inv_mixcolumns_wddl_seq #(.PRECHARGE_EN(1'b1), .CHECK_RAILS(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(ir1), .state_p(sp), .state_n(sn),
    .out_valid(ov1), .out_ready(out_ready), .result_p(rp1), .result_n(rn1), .rail_err(re1));
  aes_inv_mixcolumns_wddl_seq #(.PRECHARGE_EN(1'b0), .CHECK_RAILS(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(ir0), .state_p(sp), .state_n(sn),
    .out_valid(ov0), .out_ready(out_ready), .result_p(rp0), .result_n(rn0), .rail_err(re0));
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Waits for in_ready, offers one state, and measures accept-to-out_valid latency.
  task automatic run(input logic [127:0] p, input logic [127:0] n);
    int g = 0;
    @(negedge clk);
    while (!ir && g < 50) begin
      @(negedge clk);
      g++;
    end
    sp = p;
    sn = n;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    spc_bad = 1'b0;
    while (!ov && lat < 50) begin
      if (rp !== '0 || rn !== '0 || re !== 1'b0) spc_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_in_ready", ir1, 1'b1);
    chk("reset_out_valid", ov1, 1'b0);
    chk("reset_result_p", rp1, '0);
    chk("reset_result_n", rn1, '0);
    chk("reset_rail_err", re1, 1'b0);
    rst = 1'b0;
    run(SINGLE, ~SINGLE);
    chk("single_latency", lat, 9);
    chk("single_result_p", rp, SINGLE_X);
    chk("single_result_n", rn, ~SINGLE_X);
    chk("single_rail_err", re, 1'b0);
    chk("single_spacer", spc_bad, 1'b0);
    run(FULL, ~FULL);
    chk("full_latency", lat, 9);
    chk("full_result_p", rp, FULL_X);
    chk("full_result_n", rn, ~FULL_X);
    chk("full_spacer", spc_bad, 1'b0);
    @(negedge clk);
    chk("full_release_valid", ov, 1'b0);
    chk("full_release_spacer", rp | rn, '0);
    out_ready = 1'b0;
    run(FULL, ~FULL);
    chk("bp_latency", lat, 9);
    spc_bad = 1'b0;
    sp = SINGLE;
    sn = ~SINGLE;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (ov !== 1'b1 || ir !== 1'b0 || rp !== FULL_X || rn !== ~FULL_X) spc_bad = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_stable", spc_bad, 1'b0);
    chk("bp_held_result", rp, FULL_X);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", ov, 1'b0);
    chk("bp_release_ready", ir, 1'b1);
    chk("bp_release_spacer", rp | rn, '0);
    run(SINGLE, ~SINGLE);
    chk("bp_second_latency", lat, 9);
    chk("bp_second_result", rp, SINGLE_X);
    run(FULL, ~FULL ^ 128'h1);
    chk("fault_rail_err", re, 1'b1);
    chk("fault_result_p", rp, FULL_X);
    chk("fault_result_n", rn, ~FULL_X);
    run(FULL, ~FULL);
    chk("clean_rail_err", re, 1'b0);
    @(negedge clk);
    sp = FULL;
    sn = ~FULL;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", ir, 1'b1);
    chk("rst_out_valid", ov, 1'b0);
    chk("rst_spacer", rp | rn, '0);
    spc_bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (ov !== 1'b0) spc_bad = 1'b1;
      @(negedge clk);
    end
    chk("rst_no_valid", spc_bad, 1'b0);
    run(SINGLE, ~SINGLE);
    chk("rst_recover_latency", lat, 9);
    chk("rst_recover_result", rp, SINGLE_X);
    @(negedge clk);
    sel = 1'b1;
    run(FULL, ~FULL);
    chk("nopre_latency", lat, 5);
    chk("nopre_result_p", rp, FULL_X);
    chk("nopre_result_n", rn, ~FULL_X);
    chk("nopre_spacer", spc_bad, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
